// File: rtl/scan_sel_gen_pkg.sv
// rtl/scan_sel_gen_pkg.sv - shared state encoding and select helpers for the digit scanner
package scan_sel_gen_pkg;

  localparam int NDIG = 8;
  localparam logic [NDIG-1:0] SEL_NONE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } scan_state_t;

  // Active-low one-hot select for a digit index.
  function automatic logic [NDIG-1:0] sel_of(input logic [2:0] idx);
    return ~(NDIG'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_next_idx.sv
// rtl/scan_next_idx.sv - finds the next unmasked digit strictly after idx, searching upward mod 8
module scan_next_idx
  import scan_sel_gen_pkg::*;
(
  input  logic [2:0]      i_idx,
  input  logic [NDIG-1:0] i_mask,
  output logic [2:0]      o_next,
  output logic            o_wrap,
  output logic            o_none_left
);

  logic [2:0] w_next;

  // Scan from the farthest candidate inward so the nearest unmasked one wins;
  // offset 8 folds back onto idx itself, covering the single-digit case.
  always_comb begin
    logic [2:0] w_cand;
    w_next = i_idx;
    w_cand = i_idx;
    for (int k = NDIG; k >= 1; k--) begin
      w_cand = i_idx + 3'(k);
      if (!i_mask[w_cand]) begin
        w_next = w_cand;
      end
    end
  end

  assign o_next      = w_next;
  assign o_wrap      = (w_next <= i_idx);
  assign o_none_left = &i_mask;

endmodule

// File: rtl/scan_sel_gen.sv
// rtl/scan_sel_gen.sv - rotating active-low digit select with dwell and blanking intervals
module scan_sel_gen
  import scan_sel_gen_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_run,
  input  logic [NDIG-1:0] i_mask,
  output logic [NDIG-1:0] o_sel,
  output logic            o_en,
  output logic [2:0]      o_idx,
  output logic            o_frame_done
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  scan_state_t     r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NDIG-1:0] r_sel, w_sel_nxt;
  logic            r_en, w_en_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic            r_fd, w_fd_nxt;

  logic [2:0] w_search_idx;
  logic [2:0] w_next;
  logic       w_wrap;
  logic       w_none_left;
  logic       w_advance;

  // From IDLE, searching after index 7 yields the lowest unmasked digit.
  assign w_search_idx = (r_state == ST_IDLE) ? 3'd7 : r_idx;

  scan_next_idx u_next (
    .i_idx       (w_search_idx),
    .i_mask      (i_mask),
    .o_next      (w_next),
    .o_wrap      (w_wrap),
    .o_none_left (w_none_left)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = SEL_NONE;
    w_en_nxt    = 1'b0;
    w_idx_nxt   = r_idx;
    w_fd_nxt    = 1'b0;
    w_advance   = 1'b0;

    if (!i_run) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_none_left) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = w_next;
            w_sel_nxt   = sel_of(w_next);
            w_en_nxt    = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (r_cnt == DWELL_LAST) begin
            w_cnt_nxt = '0;
            if (BLANK_CYC > 0) begin
              w_state_nxt = ST_BLANK;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_sel_nxt = sel_of(r_idx);
            w_en_nxt  = 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_cnt_nxt = '0;
            w_advance = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase

      // Mask is only consulted here, so mid-dwell changes never cut a dwell short.
      if (w_advance) begin
        if (w_none_left) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
          w_idx_nxt   = w_next;
          w_sel_nxt   = sel_of(w_next);
          w_en_nxt    = 1'b1;
          w_fd_nxt    = w_wrap;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= SEL_NONE;
      r_en    <= 1'b0;
      r_idx   <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_idx   <= w_idx_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign o_sel        = r_sel;
  assign o_en         = r_en;
  assign o_idx        = r_idx;
  assign o_frame_done = r_fd;

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb/tb_scan_sel_gen.sv - table-driven check of the digit scanner with and without blanking
module tb_scan_sel_gen;

  typedef struct {
    int         tid;
    bit         dut;
    logic       rst;
    logic       run;
    logic [7:0] mask;
    logic [7:0] sel;
    logic       en;
    logic [2:0] idx;
    logic       fd;
  } vec_t;

  vec_t v[$];
  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, run_a = 1'b0;
  logic [7:0] mask_a = 8'h00;
  logic       rst_b = 1'b1, run_b = 1'b0;
  logic [7:0] mask_b = 8'h00;
  logic [7:0] sel_a, sel_b;
  logic       en_a, en_b, fd_a, fd_b;
  logic [2:0] idx_a, idx_b;

  always #5 clk = ~clk;

  scan_sel_gen #(.DIV(3), .BLANK_CYC(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_run(run_a), .i_mask(mask_a),
    .o_sel(sel_a), .o_en(en_a), .o_idx(idx_a), .o_frame_done(fd_a)
  );

  scan_sel_gen #(.DIV(3), .BLANK_CYC(0)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_run(run_b), .i_mask(mask_b),
    .o_sel(sel_b), .o_en(en_b), .o_idx(idx_b), .o_frame_done(fd_b)
  );

  function automatic void add(int tid, bit dut, logic rst, logic run, logic [7:0] mask,
                              logic [7:0] sel, logic en, logic [2:0] idx, logic fd);
    vec_t r;
    r.tid = tid; r.dut = dut; r.rst = rst; r.run = run; r.mask = mask;
    r.sel = sel; r.en = en; r.idx = idx; r.fd = fd;
    v.push_back(r);
  endfunction

  function automatic void dwell(int tid, bit dut, logic [7:0] mask, int d, logic fd_first, bit blank);
    logic [7:0] s;
    s = ~(8'h01 << d);
    add(tid, dut, 0, 1, mask, s, 1, 3'(d), fd_first);
    add(tid, dut, 0, 1, mask, s, 1, 3'(d), 0);
    add(tid, dut, 0, 1, mask, s, 1, 3'(d), 0);
    if (blank) add(tid, dut, 0, 1, mask, 8'hFF, 0, 3'(d), 0);
  endfunction

  initial begin
    #100000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: table not completed, total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    logic [7:0] a_sel;
    logic       a_en, a_fd;
    logic [2:0] a_idx;

    add(1, 0, 1, 1, 8'h00, 8'hFF, 0, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'hFF, 0, 0, 0);
    for (int d = 0; d < 8; d++) dwell(2, 0, 8'h00, d, 0, 1);
    dwell(2, 0, 8'h00, 0, 1, 1);
    dwell(3, 0, 8'hAA, 2, 0, 1);
    dwell(3, 0, 8'hAA, 4, 0, 1);
    dwell(3, 0, 8'hAA, 6, 0, 1);
    dwell(3, 0, 8'hAA, 0, 1, 1);
    add(5, 0, 0, 1, 8'hAA, 8'hFB, 1, 2, 0);
    add(5, 0, 0, 1, 8'hAA, 8'hFB, 1, 2, 0);
    add(5, 0, 0, 0, 8'hAA, 8'hFF, 0, 2, 0);
    add(5, 0, 0, 0, 8'hAA, 8'hFF, 0, 2, 0);
    dwell(5, 0, 8'hAA, 0, 0, 1);
    add(6, 0, 0, 1, 8'hAA, 8'hFB, 1, 2, 0);
    add(6, 0, 0, 1, 8'hFF, 8'hFB, 1, 2, 0);
    add(6, 0, 0, 1, 8'hFF, 8'hFB, 1, 2, 0);
    add(6, 0, 0, 1, 8'hFF, 8'hFF, 0, 2, 0);
    add(6, 0, 0, 1, 8'hFF, 8'hFF, 0, 2, 0);
    add(6, 0, 0, 1, 8'hFF, 8'hFF, 0, 2, 0);
    dwell(6, 0, 8'h00, 0, 0, 1);
    dwell(6, 0, 8'h00, 1, 0, 1);
    add(6, 0, 1, 1, 8'h00, 8'hFF, 0, 0, 0);
    add(4, 1, 1, 1, 8'hFB, 8'hFF, 0, 0, 0);
    dwell(4, 1, 8'hFB, 2, 0, 0);
    for (int p = 0; p < 3; p++) dwell(4, 1, 8'hFB, 2, 1, 0);
    dwell(4, 1, 8'h00, 3, 0, 0);
    dwell(4, 1, 8'h00, 4, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sel_a !== 8'hFF || en_a !== 1'b0 || idx_a !== 3'd0 || fd_a !== 1'b0 ||
        sel_b !== 8'hFF || en_b !== 1'b0 || idx_b !== 3'd0 || fd_b !== 1'b0) begin
      bad++;
      $display("FAIL reset state: a sel=%h en=%b idx=%0d fd=%b, b sel=%h en=%b idx=%0d fd=%b",
               sel_a, en_a, idx_a, fd_a, sel_b, en_b, idx_b, fd_b);
    end

    for (int i = 0; i < v.size(); i++) begin
      if (v[i].dut == 0) begin
        rst_a = v[i].rst; run_a = v[i].run; mask_a = v[i].mask;
        rst_b = 1'b1;
      end else begin
        rst_b = v[i].rst; run_b = v[i].run; mask_b = v[i].mask;
        rst_a = 1'b1;
      end
      @(posedge clk);
      #1;
      if (v[i].dut == 0) begin
        a_sel = sel_a; a_en = en_a; a_idx = idx_a; a_fd = fd_a;
      end else begin
        a_sel = sel_b; a_en = en_b; a_idx = idx_b; a_fd = fd_b;
      end
      total++;
      if (a_sel !== v[i].sel || a_en !== v[i].en || a_idx !== v[i].idx || a_fd !== v[i].fd) begin
        bad++;
        $display("FAIL test%0d row%0d: got sel=%h en=%b idx=%0d fd=%b, expected sel=%h en=%b idx=%0d fd=%b",
                 v[i].tid, i, a_sel, a_en, a_idx, a_fd, v[i].sel, v[i].en, v[i].idx, v[i].fd);
      end
    end

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
